// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake between the fetch stage and alu_issue_ctrl.
// master = instruction source, slave = issue controller.
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue front end for the 8-bit combinational alu.
// Decodes 16-bit instructions, feeds registered operands from a 16x8
// register file to the alu, and writes the result back.
// Optional: define ALU_ISSUE_ZFLAG_EN to add the registered "zero" output.
//
// state     | meaning
// ----------+---------------------------------------------------------
// st_idle   | ready for an instruction; accept decodes and loads alu_*
// st_exec   | alu operands stable; result captured at the next edge
// st_done   | done pulse (result/err valid), then back to st_idle
module alu_issue_ctrl #(
    parameter int NREGS = 16,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave ifc,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [2:0]      alu_ctrl,
    output logic            alu_flag,
    input  logic [DW-1:0]   alu_out,
    output logic            done,
    output logic            err,
    output logic [DW-1:0]   result,
    input  logic [3:0]      dbg_addr,
    output logic [DW-1:0]   dbg_data
`ifdef ALU_ISSUE_ZFLAG_EN
    ,
    output logic            zero
`endif
);

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_exec = 2'd1;
    localparam logic [1:0] st_done = 2'd2;

    logic [1:0]    st;
    logic [DW-1:0] rf [NREGS];
    logic [3:0]    rd_q;

    logic [3:0]    op, rd, rs1, rs2;
    logic [DW-1:0] imm8;
    logic [DW-1:0] rs1_val, rs2_val;
    logic [2:0]    dec_ctrl;
    logic          dec_flag;
    logic          dec_alu;
    logic          dec_li;
    logic          accept;

    logic          rf_we;
    logic [3:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    assign op   = ifc.instr[15:12];
    assign rd   = ifc.instr[11:8];
    assign rs1  = ifc.instr[7:4];
    assign rs2  = ifc.instr[3:0];
    assign imm8 = ifc.instr[7:0];

    // r0 is hard-wired to zero on every read path
    assign rs1_val  = (rs1 == 4'd0)      ? '0 : rf[rs1];
    assign rs2_val  = (rs2 == 4'd0)      ? '0 : rf[rs2];
    assign dbg_data = (dbg_addr == 4'd0) ? '0 : rf[dbg_addr];

    // Ready only in idle and never while reset is being applied
    assign ifc.instr_ready = (st == st_idle) && !rst;
    assign accept          = ifc.instr_valid && ifc.instr_ready;

    // Opcode decode to alu ctrl/flag; anything not alu or LI is illegal
    always_comb begin
        dec_ctrl = 3'b000;
        dec_flag = 1'b0;
        dec_alu  = 1'b0;
        dec_li   = 1'b0;
        case (op)
            4'h0: begin dec_ctrl = 3'b000; dec_flag = 1'b0; dec_alu = 1'b1; end
            4'h1: begin dec_ctrl = 3'b000; dec_flag = 1'b1; dec_alu = 1'b1; end
            4'h2: begin dec_ctrl = 3'b001; dec_flag = 1'b0; dec_alu = 1'b1; end
            4'h3: begin dec_ctrl = 3'b001; dec_flag = 1'b1; dec_alu = 1'b1; end
            4'h4: begin dec_ctrl = 3'b010; dec_flag = 1'b0; dec_alu = 1'b1; end
            4'h5: begin dec_ctrl = 3'b011; dec_flag = 1'b1; dec_alu = 1'b1; end
            4'h6: begin dec_ctrl = 3'b011; dec_flag = 1'b0; dec_alu = 1'b1; end
            4'h7: begin dec_ctrl = 3'b100; dec_flag = 1'b0; dec_alu = 1'b1; end
            4'h8: dec_li = 1'b1;
            default: ;
        endcase
    end

    // Register-file write port: LI at accept, alu result at end of exec
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_out;
        if ((st == st_idle) && accept && dec_li) begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = imm8;
        end else if (st == st_exec) begin
            rf_we = 1'b1;
        end
        if (rf_waddr == 4'd0) begin
            rf_we = 1'b0;
        end
    end

    // Register file storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Issue FSM, alu operand registers and retire outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= st_idle;
            rd_q     <= 4'd0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= 3'b000;
            alu_flag <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
`ifdef ALU_ISSUE_ZFLAG_EN
            zero     <= 1'b0;
`endif
        end else begin
            case (st)
                st_idle: begin
                    if (accept) begin
                        rd_q <= rd;
                        if (dec_alu) begin
                            alu_a    <= rs1_val;
                            alu_b    <= rs2_val;
                            alu_ctrl <= dec_ctrl;
                            alu_flag <= dec_flag;
                            st       <= st_exec;
                        end else if (dec_li) begin
                            result <= imm8;
                            err    <= 1'b0;
                            done   <= 1'b1;
`ifdef ALU_ISSUE_ZFLAG_EN
                            zero   <= (imm8 == '0);
`endif
                            st     <= st_done;
                        end else begin
                            result <= '0;
                            err    <= 1'b1;
                            done   <= 1'b1;
`ifdef ALU_ISSUE_ZFLAG_EN
                            zero   <= 1'b1;
`endif
                            st     <= st_done;
                        end
                    end
                end
                st_exec: begin
                    result <= alu_out;
                    err    <= 1'b0;
                    done   <= 1'b1;
`ifdef ALU_ISSUE_ZFLAG_EN
                    zero   <= (alu_out == '0);
`endif
                    st     <= st_done;
                end
                st_done: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    st   <= st_idle;
                end
                default: st <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural alu model.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [7:0] res;
        logic       err;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] ctrl;
        logic       flag;
        logic       is_alu;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_a, alu_b, alu_out, result, dbg_data;
    logic [2:0] alu_ctrl;
    logic       alu_flag, done, err;
    logic [3:0] dbg_addr;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic       zero;
`endif

    alu_issue_ctrl_if ifc ();

    alu_issue_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ifc      (ifc),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .alu_flag (alu_flag),
        .alu_out  (alu_out),
        .done     (done),
        .err      (err),
        .result   (result),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`ifdef ALU_ISSUE_ZFLAG_EN
        ,
        .zero     (zero)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // behavioural model of the team alu
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_out = alu_flag ? (alu_a - alu_b) : (alu_a + alu_b);
            3'b001:  alu_out = alu_flag ? ~(alu_a & alu_b) : ~(alu_a | alu_b);
            3'b010:  alu_out = {7'd0, (alu_a < alu_b)};
            3'b011:  alu_out = alu_flag ? (alu_a << alu_b[2:0]) : (alu_a >> alu_b[2:0]);
            3'b100:  alu_out = $signed(alu_a) >>> alu_b[2:0];
            default: alu_out = 8'h00;
        endcase
    end

    int         vectors = 0;
    int         miscompares = 0;
    exp_t       sb[$];
    logic [7:0] ref_rf [16];
    logic [7:0] last_a, last_b;
    logic [2:0] last_ctrl;
    logic       last_flag;

    logic [7:0] obs_a, obs_b, obs_res;
    logic [2:0] obs_ctrl;
    logic       obs_flag, obs_err, obs_zero;
    int         obs_lat;

    task automatic clear_model();
        for (int i = 0; i < 16; i++) ref_rf[i] = 8'h00;
        last_a = 8'h00; last_b = 8'h00; last_ctrl = 3'b000; last_flag = 1'b0;
    endtask

    // reference: expected retire values computed from the opcode semantics
    task automatic model(input logic [15:0] w, output exp_t e);
        logic [3:0] op;
        logic [7:0] a, b;
        logic [2:0] c;
        logic       f;
        op = w[15:12];
        a = (w[7:4] == 4'd0) ? 8'h00 : ref_rf[w[7:4]];
        b = (w[3:0] == 4'd0) ? 8'h00 : ref_rf[w[3:0]];
        c = 3'b000; f = 1'b0;
        e.err = 1'b0; e.is_alu = 1'b1; e.res = 8'h00;
        case (op)
            4'h0: begin e.res = a + b;                     c = 3'b000; f = 1'b0; end
            4'h1: begin e.res = a - b;                     c = 3'b000; f = 1'b1; end
            4'h2: begin e.res = ~(a | b);                  c = 3'b001; f = 1'b0; end
            4'h3: begin e.res = ~(a & b);                  c = 3'b001; f = 1'b1; end
            4'h4: begin e.res = (a < b) ? 8'h01 : 8'h00;   c = 3'b010; f = 1'b0; end
            4'h5: begin e.res = a << b[2:0];               c = 3'b011; f = 1'b1; end
            4'h6: begin e.res = a >> b[2:0];               c = 3'b011; f = 1'b0; end
            4'h7: begin e.res = $signed(a) >>> b[2:0];     c = 3'b100; f = 1'b0; end
            4'h8: begin e.res = w[7:0]; e.is_alu = 1'b0; end
            default: begin e.err = 1'b1; e.is_alu = 1'b0; end
        endcase
        if (e.is_alu) begin
            last_a = a; last_b = b; last_ctrl = c; last_flag = f;
        end
        e.a = last_a; e.b = last_b; e.ctrl = last_ctrl; e.flag = last_flag;
        if (!e.err && w[11:8] != 4'd0) ref_rf[w[11:8]] = e.res;
    endtask

    // drive one instruction, push its expectation, observe the retire
    task automatic send(input logic [15:0] w);
        int   n;
        exp_t e;
        @(negedge clk);
        ifc.instr_valid = 1'b1;
        ifc.instr = w;
        n = 0;
        while (!ifc.instr_ready && n < 20) begin @(negedge clk); n++; end
        if (!ifc.instr_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_ready_timeout instr=%h ready=0 want=1", w);
        end
        model(w, e);
        sb.push_back(e);
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        obs_a = alu_a; obs_b = alu_b; obs_ctrl = alu_ctrl; obs_flag = alu_flag;
        obs_lat = 1;
        while (!done && obs_lat < 10) begin @(negedge clk); obs_lat++; end
        obs_res = result; obs_err = err;
`ifdef ALU_ISSUE_ZFLAG_EN
        obs_zero = zero;
`else
        obs_zero = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.instr_valid = 1'b0; ifc.instr = 16'h0000; dbg_addr = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_model();
        #1;
        vectors++; if (ifc.instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b want=1", ifc.instr_ready); end
        vectors++; if ({done, err} !== 2'b00) begin miscompares++; $display("FAIL reset_done_err got=%b want=00", {done, err}); end
        vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL reset_result got=%h want=00", result); end
        vectors++; if ({alu_a, alu_b, alu_ctrl, alu_flag} !== 20'h0) begin
            miscompares++; $display("FAIL reset_alu got=%h/%h/%b/%b want=0", alu_a, alu_b, alu_ctrl, alu_flag);
        end
        dbg_addr = 4'd5; #1;
        vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL reset_rf got=%h want=00", dbg_data); end
    endtask

    task automatic test_alu_ops();
        logic [15:0] prog [14];
        exp_t        e;
        prog = '{16'h810F, 16'h820A, 16'h0312, 16'h1421, 16'h3512, 16'h86F0, 16'h8702,
                 16'h7867, 16'h6967, 16'h4A12, 16'h4A16, 16'h5B17, 16'h2C12, 16'h8D00};
        foreach (prog[i]) begin
            send(prog[i]);
            e = sb.pop_front();
            vectors++; if (obs_res !== e.res || obs_err !== e.err) begin
                miscompares++; $display("FAIL op_result instr=%h got=%h/%b want=%h/%b", prog[i], obs_res, obs_err, e.res, e.err);
            end
            vectors++; if (obs_lat !== (e.is_alu ? 2 : 1)) begin
                miscompares++; $display("FAIL op_latency instr=%h got=%0d want=%0d", prog[i], obs_lat, e.is_alu ? 2 : 1);
            end
            if (e.is_alu) begin
                vectors++; if ({obs_a, obs_b, obs_ctrl, obs_flag} !== {e.a, e.b, e.ctrl, e.flag}) begin
                    miscompares++; $display("FAIL op_operands instr=%h got=%h/%h/%b/%b want=%h/%h/%b/%b",
                        prog[i], obs_a, obs_b, obs_ctrl, obs_flag, e.a, e.b, e.ctrl, e.flag);
                end
            end
`ifdef ALU_ISSUE_ZFLAG_EN
            vectors++; if (obs_zero !== (e.res == 8'h00)) begin
                miscompares++; $display("FAIL op_zero instr=%h got=%b want=%b", prog[i], obs_zero, e.res == 8'h00);
            end
`endif
        end
        for (int r = 0; r < 16; r++) begin
            dbg_addr = r[3:0]; #1;
            vectors++; if (dbg_data !== ref_rf[r]) begin
                miscompares++; $display("FAIL rf_readback r%0d got=%h want=%h", r, dbg_data, ref_rf[r]);
            end
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        send(16'hF123);
        e = sb.pop_front();
        vectors++; if ({obs_err, obs_res} !== {e.err, e.res} || e.err !== 1'b1) begin
            miscompares++; $display("FAIL illegal_err got=%b/%h want=1/00", obs_err, obs_res);
        end
        vectors++; if (obs_lat !== 1) begin miscompares++; $display("FAIL illegal_latency got=%0d want=1", obs_lat); end
        vectors++; if ({obs_a, obs_b, obs_ctrl, obs_flag} !== {e.a, e.b, e.ctrl, e.flag}) begin
            miscompares++; $display("FAIL illegal_alu_held got=%h/%h/%b/%b want=%h/%h/%b/%b",
                obs_a, obs_b, obs_ctrl, obs_flag, e.a, e.b, e.ctrl, e.flag);
        end
        @(negedge clk);
        vectors++; if (ifc.instr_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++; $display("FAIL illegal_ready_back got=%b/%b want=1/0", ifc.instr_ready, done);
        end
        for (int r = 0; r < 16; r++) begin
            dbg_addr = r[3:0]; #1;
            vectors++; if (dbg_data !== ref_rf[r]) begin
                miscompares++; $display("FAIL illegal_rf_kept r%0d got=%h want=%h", r, dbg_data, ref_rf[r]);
            end
        end
    endtask

    task automatic test_r0();
        exp_t e;
        send(16'h8055);
        e = sb.pop_front();
        vectors++; if (obs_res !== e.res) begin miscompares++; $display("FAIL r0_li_result got=%h want=%h", obs_res, e.res); end
        dbg_addr = 4'd0; #1;
        vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL r0_read got=%h want=00", dbg_data); end
        send(16'h0102);
        e = sb.pop_front();
        vectors++; if (obs_a !== 8'h00 || obs_res !== e.res) begin
            miscompares++; $display("FAIL r0_operand got=%h/%h want=00/%h", obs_a, obs_res, e.res);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        int seen;
        @(negedge clk);
        ifc.instr_valid = 1'b1; ifc.instr = 16'h0312;
        n = 0;
        while (!ifc.instr_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        rst = 1'b1;
        seen = 0;
        @(negedge clk);
        seen += done;
        rst = 1'b0;
        clear_model();
        #1;
        vectors++; if (ifc.instr_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got=%b want=1", ifc.instr_ready); end
        repeat (3) begin @(negedge clk); seen += done; end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_done got=%0d pulses want=0", seen); end
        dbg_addr = 4'd3; #1;
        vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL abort_no_write got=%h want=00", dbg_data); end
    endtask

    task automatic test_valid_through_reset();
        exp_t e;
        int   seen;
        @(negedge clk);
        rst = 1'b1;
        ifc.instr_valid = 1'b1; ifc.instr = 16'h8133;
        seen = 0;
        repeat (2) begin @(negedge clk); seen += done; end
        rst = 1'b0;
        clear_model();
        #1;
        vectors++; if (ifc.instr_ready !== 1'b1 || seen !== 0) begin
            miscompares++; $display("FAIL hold_reset_ready got=%b/%0d want=1/0", ifc.instr_ready, seen);
        end
        model(16'h8133, e);
        sb.push_back(e);
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        e = sb.pop_front();
        vectors++; if (done !== 1'b1 || result !== e.res || err !== 1'b0) begin
            miscompares++; $display("FAIL hold_reset_accept got=%b/%h/%b want=1/%h/0", done, result, err, e.res);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ws [5];
        int          t [5];
        int          exp_sp [4];
        int          k;
        exp_t        e;
        send(16'h8205);
        e = sb.pop_front();
        ws = '{16'h0B12, 16'h1CB1, 16'h0DCC, 16'h8E00, 16'h8F7F};
        exp_sp = '{3, 3, 3, 2};
        @(negedge clk);
        ifc.instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            k = 0;
            while (!ifc.instr_ready && k < 20) begin
                if (done && sb.size() > 0) begin
                    e = sb.pop_front();
                    vectors++; if (result !== e.res || err !== e.err) begin
                        miscompares++; $display("FAIL b2b_result got=%h/%b want=%h/%b", result, err, e.res, e.err);
                    end
                end
                @(negedge clk); k++;
            end
            if (!ifc.instr_ready) begin
                vectors++; miscompares++; $display("FAIL b2b_ready_timeout idx=%0d ready=0 want=1", i);
            end
            ifc.instr = ws[i];
            model(ws[i], e);
            sb.push_back(e);
            t[i] = cyc;
            @(negedge clk);
        end
        ifc.instr_valid = 1'b0;
        k = 0;
        while (sb.size() > 0 && k < 20) begin
            if (done) begin
                e = sb.pop_front();
                vectors++; if (result !== e.res || err !== e.err) begin
                    miscompares++; $display("FAIL b2b_result got=%h/%b want=%h/%b", result, err, e.res, e.err);
                end
            end
            @(negedge clk); k++;
        end
        vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL b2b_drain got=%0d pending want=0", sb.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (t[i+1] - t[i] !== exp_sp[i]) begin
                miscompares++; $display("FAIL b2b_spacing idx=%0d got=%0d want=%0d", i, t[i+1] - t[i], exp_sp[i]);
            end
        end
        for (int r = 11; r < 16; r++) begin
            dbg_addr = r[3:0]; #1;
            vectors++; if (dbg_data !== ref_rf[r]) begin
                miscompares++; $display("FAIL b2b_rf r%0d got=%h want=%h", r, dbg_data, ref_rf[r]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_illegal();
        test_r0();
        test_reset_abort();
        test_valid_through_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
